// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin ALU/MEM writeback onto one RF write port; WB_PERF_CNT_EN adds conflict_cnt.
// Latency: accept -> rf_write_d after 1 edge; backpressure: x_ready = FIFO not full (forced low in reset).

module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_i,
  input  logic [W-1:0]              push_dat_i,
  input  logic                      pop_i,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [W-1:0]              head_o,
  output logic [DEPTH-1:0]          vld_o,
  output logic [DEPTH-1:0][W-1:0]   ents_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [PW-1:0]           wptr_q, rptr_q;

  // Per-slot valid bits track occupancy and also feed the hazard compare.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rptr_q] = 1'b0;
    if (push_i) vld_d[wptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_dat_i;
  end

  assign full_o  = &vld_q;
  assign empty_o = ~|vld_q;
  assign head_o  = mem_q[rptr_q];
  assign vld_o   = vld_q;
  assign ents_o  = mem_q;
endmodule

module rf_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  output logic              rf_write_d,
  output logic [ADDR_W-1:0] rf_addr3,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard1,
`ifdef WB_PERF_CNT_EN
  output logic [15:0]       conflict_cnt,
`endif
  output logic              hazard2
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dat;
  } wb_ent_t;

  localparam int EW = $bits(wb_ent_t);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  src_e rr_q, rr_d;

  logic alu_full, alu_empty, mem_full, mem_empty;
  logic alu_push, mem_push, alu_pop, mem_pop;
  logic [EW-1:0] alu_head, mem_head;
  logic [DEPTH-1:0] alu_vld, mem_vld;
  logic [DEPTH-1:0][EW-1:0] alu_ents, mem_ents;
  logic [DATA_W-1:0] mem_ext;
  wb_ent_t alu_in, mem_in, grant_ent;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Ready never depends on valid; rst is folded in so ready reads 0 during reset.
  assign alu_ready = !alu_full && !rst;
  assign mem_ready = !mem_full && !rst;

  // Writes to x0 are swallowed at the handshake.
  assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
  assign mem_push = mem_valid && mem_ready && (mem_addr != '0);

  always_comb begin
    mem_ext = mem_data;
    case (mem_size)
      2'b01:   mem_ext = {{(DATA_W-16){mem_sign & mem_data[15]}}, mem_data[15:0]};
      2'b10:   mem_ext = {{(DATA_W-8){mem_sign & mem_data[7]}}, mem_data[7:0]};
      default: mem_ext = mem_data;
    endcase
  end

  assign alu_in = '{addr: alu_addr, dat: alu_data};
  assign mem_in = '{addr: mem_addr, dat: mem_ext};

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
    .clk(clk), .rst(rst), .push_i(alu_push), .push_dat_i(alu_in), .pop_i(alu_pop),
    .full_o(alu_full), .empty_o(alu_empty), .head_o(alu_head), .vld_o(alu_vld), .ents_o(alu_ents)
  );

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_mem_fifo (
    .clk(clk), .rst(rst), .push_i(mem_push), .push_dat_i(mem_in), .pop_i(mem_pop),
    .full_o(mem_full), .empty_o(mem_empty), .head_o(mem_head), .vld_o(mem_vld), .ents_o(mem_ents)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q   <= SRC_ALU;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      rr_q   <= rr_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Whatever is granted, the pointer ends up naming the other source.
  always_comb begin
    alu_pop   = 1'b0;
    mem_pop   = 1'b0;
    rr_d      = rr_q;
    grant_ent = wb_ent_t'(alu_head);
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    if (!alu_empty && (mem_empty || rr_q == SRC_ALU)) begin
      alu_pop   = 1'b1;
      rr_d      = SRC_MEM;
      grant_ent = wb_ent_t'(alu_head);
    end else if (!mem_empty) begin
      mem_pop   = 1'b1;
      rr_d      = SRC_ALU;
      grant_ent = wb_ent_t'(mem_head);
    end
    if (alu_pop || mem_pop) begin
      wr_d   = 1'b1;
      addr_d = grant_ent.addr;
      data_d = grant_ent.dat;
    end
  end

  assign rf_write_d = wr_q;
  assign rf_addr3   = addr_q;
  assign rf_data_in = data_q;

  always_comb begin
    wb_ent_t e;
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      e = wb_ent_t'(alu_ents[i]);
      if (alu_vld[i] && e.addr == rd_addr1) hazard1 = 1'b1;
      if (alu_vld[i] && e.addr == rd_addr2) hazard2 = 1'b1;
      e = wb_ent_t'(mem_ents[i]);
      if (mem_vld[i] && e.addr == rd_addr1) hazard1 = 1'b1;
      if (mem_vld[i] && e.addr == rd_addr2) hazard2 = 1'b1;
    end
    if (wr_q && addr_q == rd_addr1) hazard1 = 1'b1;
    if (wr_q && addr_q == rd_addr2) hazard2 = 1'b1;
    if (rd_addr1 == '0) hazard1 = 1'b0;
    if (rd_addr2 == '0) hazard2 = 1'b0;
  end

`ifdef WB_PERF_CNT_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (!alu_empty && !mem_empty && conflict_q != 16'hFFFF) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`endif
endmodule
